// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter.
// The master drives the controls; the slave (the counter) returns count and flags.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrap;
  logic             ovf;
  logic [WIDTH-1:0] tgl;

  modport master (
    output clr, load, load_val, en, up, ovf_clr,
    input  count, at_max, at_min, wrap, ovf, tgl
  );

  modport slave (
    input  clr, load, load_val, en, up, ovf_clr,
    output count, at_max, at_min, wrap, ovf, tgl
  );

endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with a programmable terminal value and wrap/saturate mode.
// Also provides a range-end pulse, a sticky overflow flag and a per-bit toggle report.
module mod_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  // Reject parameter sets the WIDTH-bit arithmetic cannot represent.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("mod_updown_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tgl_q,   tgl_d;
  logic             wrap_q,  wrap_d;
  logic             ovf_q,   ovf_d;
  logic             evt;

  // Next-state: clr > load > en; a blocked or wrapped step is a range-end event.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    evt     = 1'b0;

    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (count_q == MAX_W) begin
          evt     = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          evt     = 1'b1;
          count_d = (SATURATE != 0) ? count_q : MAX_W;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end

    // A same-edge event outranks ovf_clr; clr outranks both.
    if (bus.clr) begin
      ovf_d = 1'b0;
    end else begin
      if (bus.ovf_clr) ovf_d = 1'b0;
      if (evt)         ovf_d = 1'b1;
    end

    wrap_d = evt;
    tgl_d  = count_q ^ count_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tgl_q   <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tgl_q   <= tgl_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.tgl    = tgl_q;
  assign bus.wrap   = wrap_q;
  assign bus.ovf    = ovf_q;
  assign bus.at_max = (count_q == MAX_W);
  assign bus.at_min = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: three instances cover the default wrap,
// a MAX_VAL=9 wrap counter and a MAX_VAL=5 saturating counter.
module tb_mod_updown_counter;

  logic clk;
  logic rst;

  int unsigned checks;
  int unsigned errors;

  int unsigned t3_cnt  [4] = '{4, 5, 5, 5};
  int unsigned t3_wrap [4] = '{0, 0, 1, 1};

  mod_updown_counter_if #(.WIDTH(4)) if_def ();
  mod_updown_counter_if #(.WIDTH(4)) if_m9  ();
  mod_updown_counter_if #(.WIDTH(4)) if_sat ();

  mod_updown_counter #(.WIDTH(4)) u_def (
    .clk (clk),
    .rst (rst),
    .bus (if_def.slave)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_m9 (
    .clk (clk),
    .rst (rst),
    .bus (if_m9.slave)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(5), .SATURATE(1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (if_sat.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    {if_def.clr, if_def.load, if_def.en, if_def.up, if_def.ovf_clr} = '0;
    {if_m9.clr,  if_m9.load,  if_m9.en,  if_m9.up,  if_m9.ovf_clr}  = '0;
    {if_sat.clr, if_sat.load, if_sat.en, if_sat.up, if_sat.ovf_clr} = '0;
    if_def.load_val = '0;
    if_m9.load_val  = '0;
    if_sat.load_val = '0;

    // Reset state
    #12;
    chk("rst_count",  32'(if_def.count),  32'd0);
    chk("rst_at_min", 32'(if_def.at_min), 32'd1);
    chk("rst_at_max", 32'(if_def.at_max), 32'd0);
    chk("rst_wrap",   32'(if_def.wrap),   32'd0);
    chk("rst_ovf",    32'(if_def.ovf),    32'd0);
    chk("rst_tgl",    32'(if_def.tgl),    32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Default counter wraps 15 -> 0
    if_def.en = 1'b1;
    if_def.up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("t1_count", 32'(if_def.count), 32'(i % 16));
      chk("t1_wrap",  32'(if_def.wrap),  32'(i == 16));
      if (i == 15) chk("t1_at_max", 32'(if_def.at_max), 32'd1);
      if (i == 16) chk("t1_tgl",    32'(if_def.tgl),    32'hF);
    end
    chk("t1_ovf", 32'(if_def.ovf), 32'd1);
    if_def.en = 1'b0;

    // MAX_VAL=9 counting down from 0
    if_m9.en = 1'b1;
    if_m9.up = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("t2_count",  32'(if_m9.count),  32'((10 - (i % 10)) % 10));
      chk("t2_wrap",   32'(if_m9.wrap),   32'(i == 1 || i == 11));
      chk("t2_at_min", 32'(if_m9.at_min), 32'(i == 10));
    end
    if_m9.en = 1'b0;

    // Saturating counter holds at 5
    if_sat.load     = 1'b1;
    if_sat.load_val = 4'd3;
    tick();
    chk("t3_load", 32'(if_sat.count), 32'd3);
    if_sat.load = 1'b0;
    if_sat.en   = 1'b1;
    if_sat.up   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_count", 32'(if_sat.count), t3_cnt[i]);
      chk("t3_wrap",  32'(if_sat.wrap),  t3_wrap[i]);
    end
    chk("t3_ovf",    32'(if_sat.ovf),    32'd1);
    chk("t3_tgl",    32'(if_sat.tgl),    32'd0);
    chk("t3_at_max", 32'(if_sat.at_max), 32'd1);
    if_sat.en       = 1'b0;
    if_sat.load     = 1'b1;
    if_sat.load_val = 4'd7;
    tick();
    chk("t3_clamp", 32'(if_sat.count), 32'd5);
    if_sat.load_val = 4'd0;
    tick();
    if_sat.load = 1'b0;
    if_sat.en   = 1'b1;
    if_sat.up   = 1'b0;
    tick();
    chk("t3_low_hold", 32'(if_sat.count), 32'd0);
    chk("t3_low_wrap", 32'(if_sat.wrap),  32'd1);
    if_sat.en = 1'b0;

    // clr beats load and en; out-of-range load clamps to 9
    if_m9.load     = 1'b1;
    if_m9.load_val = 4'd7;
    tick();
    chk("t4_pre", 32'(if_m9.count), 32'd7);
    if_m9.clr      = 1'b1;
    if_m9.en       = 1'b1;
    if_m9.load_val = 4'd3;
    tick();
    chk("t4_clr_count", 32'(if_m9.count), 32'd0);
    chk("t4_clr_ovf",   32'(if_m9.ovf),   32'd0);
    if_m9.clr      = 1'b0;
    if_m9.en       = 1'b0;
    if_m9.load_val = 4'd12;
    tick();
    chk("t4_clamp",  32'(if_m9.count),  32'd9);
    chk("t4_tgl",    32'(if_m9.tgl),    32'd9);
    chk("t4_at_max", 32'(if_m9.at_max), 32'd1);
    if_m9.load = 1'b0;

    // ovf_clr alone clears; ovf_clr during a wrap leaves ovf set
    if_def.ovf_clr = 1'b1;
    tick();
    chk("t5_clr_ovf",  32'(if_def.ovf),   32'd0);
    chk("t5_hold",     32'(if_def.count), 32'd1);
    chk("t5_hold_tgl", 32'(if_def.tgl),   32'd0);
    if_def.ovf_clr  = 1'b0;
    if_def.load     = 1'b1;
    if_def.load_val = 4'd15;
    tick();
    if_def.load    = 1'b0;
    if_def.en      = 1'b1;
    if_def.up      = 1'b1;
    if_def.ovf_clr = 1'b1;
    tick();
    chk("t5_wrap_count", 32'(if_def.count), 32'd0);
    chk("t5_wrap_pulse", 32'(if_def.wrap),  32'd1);
    chk("t5_evt_wins",   32'(if_def.ovf),   32'd1);
    tick();
    chk("t5_noevt_clr", 32'(if_def.ovf),  32'd0);
    chk("t5_wrap_drop", 32'(if_def.wrap), 32'd0);
    if_def.ovf_clr  = 1'b0;
    if_def.en       = 1'b0;
    if_def.load     = 1'b1;
    if_def.load_val = 4'd0;
    tick();
    if_def.load = 1'b0;
    if_def.en   = 1'b1;
    if_def.up   = 1'b0;
    tick();
    chk("t5_down_wrap", 32'(if_def.count), 32'd15);
    chk("t5_down_ovf",  32'(if_def.ovf),   32'd1);

    // Asynchronous reset between edges with a load pending
    if_def.en       = 1'b0;
    if_def.load     = 1'b1;
    if_def.load_val = 4'd6;
    tick();
    chk("t6_pre_count", 32'(if_def.count), 32'd6);
    chk("t6_pre_tgl",   32'(if_def.tgl),   32'd9);
    chk("t6_pre_ovf",   32'(if_def.ovf),   32'd1);
    if_def.load_val = 4'd9;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_count",  32'(if_def.count),  32'd0);
    chk("t6_ovf",    32'(if_def.ovf),    32'd0);
    chk("t6_wrap",   32'(if_def.wrap),   32'd0);
    chk("t6_tgl",    32'(if_def.tgl),    32'd0);
    chk("t6_at_min", 32'(if_def.at_min), 32'd1);
    @(posedge clk);
    #1;
    chk("t6_held", 32'(if_def.count), 32'd0);
    @(negedge clk);
    rst         = 1'b1;
    if_def.load = 1'b0;
    if_def.en   = 1'b1;
    if_def.up   = 1'b1;
    tick();
    chk("t6_resume",     32'(if_def.count), 32'd1);
    chk("t6_resume_tgl", 32'(if_def.tgl),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
